frame_buffer_dbl: RTL

Parametrised double-buffered indexed-colour frame buffer between the drawing logic and the HDMI text/graphics controller. The drawing side writes palette indices by (x, y) into the back bank while the scan-out side reads the front bank, through a run-time-writable palette, as 12-bit RGB. Banks swap only at vertical sync, so no frame is ever shown torn. A hardware clear engine fills the back bank with a constant index.

---
 rtl/frame_buffer_pkg.sv | 28 ++
 rtl/fb_bank.sv | 41 ++++
 rtl/frame_buffer_dbl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg
// Shared types and constants for the double-buffered indexed-colour frame
// buffer: the 12-bit RGB pixel type, the clear-engine state encoding and the
// palette contents loaded at reset.
package frame_buffer_pkg;

  // {R4, G4, B4}
  typedef logic [11:0] rgb12_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

  // Palette contents after reset: black, white, red, blue, then black.
  function automatic rgb12_t default_palette(input int idx);
    rgb12_t rgb;
    case (idx)
      0:       rgb = 12'h000;
      1:       rgb = 12'hFFF;
      2:       rgb = 12'hF00;
      3:       rgb = 12'h00F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// fb_bank
// One bank of pixel-index storage: a simple dual-port block RAM with one
// synchronous write port and one registered read port (one-cycle read
// latency). Contents are never reset.
//
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data (palette index)
//   raddr_i  - read address
//   rdata_o  - registered read data
module fb_bank
  import frame_buffer_pkg::*;
#(
  parameter int    DEPTH     = 76800,
  parameter int    DW        = 2,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  (* ram_style = "block" *) logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// frame_buffer_dbl
// Double-buffered indexed-colour frame buffer. The drawing side writes
// palette indices by (x, y) into the back bank; scan-out reads the front bank
// through a writable palette as 12-bit RGB. Banks swap only on vsync, and a
// clear engine fills the back bank with CLEAR_IDX, one address per cycle.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   wr_en_i/x/y/idx   - pixel write into the back bank; wr_ready_o = !busy
//   rd_valid_i/x/y    - scan-out read of the front bank
//   rgb_out_o         - {R4,G4,B4} result, 3 cycles after the read strobe
//   rgb_valid_o       - rgb_out_o holds a read result this cycle
//   pal_we_i/addr/rgb - palette entry write
//   swap_req_i        - request bank swap at the next eligible vsync
//   vsync_i           - one-cycle frame-end pulse
//   clear_req_i       - start clearing the back bank
//   busy_o            - clear in progress
//   swap_pending_o    - swap requested but not yet applied
//   front_sel_o       - bank currently scanned out
module frame_buffer_dbl
  import frame_buffer_pkg::*;
#(
  parameter int    WIDTH_PX  = 320,
  parameter int    HEIGHT_PX = 240,
  parameter int    PIX_BITS  = 2,
  parameter int    CLEAR_IDX = 0,
  parameter string INIT_FILE = "bf.txt",
  localparam int   N         = WIDTH_PX * HEIGHT_PX,
  localparam int   AW        = $clog2(N),
  localparam int   XW        = $clog2(WIDTH_PX),
  localparam int   YW        = $clog2(HEIGHT_PX)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [XW-1:0]       wr_x_i,
  input  logic [YW-1:0]       wr_y_i,
  input  logic [PIX_BITS-1:0] wr_idx_i,
  output logic                wr_ready_o,
  input  logic                rd_valid_i,
  input  logic [XW-1:0]       rd_x_i,
  input  logic [YW-1:0]       rd_y_i,
  output logic [11:0]         rgb_out_o,
  output logic                rgb_valid_o,
  input  logic                pal_we_i,
  input  logic [PIX_BITS-1:0] pal_addr_i,
  input  logic [11:0]         pal_rgb_i,
  input  logic                swap_req_i,
  input  logic                vsync_i,
  input  logic                clear_req_i,
  output logic                busy_o,
  output logic                swap_pending_o,
  output logic                front_sel_o
);

  localparam int PAL_N = 2 ** PIX_BITS;
  // Limits are one bit wider than the coordinates so power-of-two sizes work.
  localparam logic [XW:0] X_LIM = (XW + 1)'(WIDTH_PX);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(HEIGHT_PX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(WIDTH_PX);

  // Control state
  fb_state_t     state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          front_sel_q, front_sel_d;
  logic          swap_pending_q, swap_pending_d;
  logic          busy;

  // Write path (address stage)
  logic                wr_ok;
  logic [AW-1:0]       wr_addr_d;
  logic                wr_en_q;
  logic [AW-1:0]       wr_addr_q;
  logic [PIX_BITS-1:0] wr_idx_q;
  logic                wr_bank_q;

  // Read path: stage 1 address, stage 2 BRAM, stage 3 palette
  logic                     rd_oob_d;
  logic [AW-1:0]            rd_addr_d;
  logic                     rd_v1_q, rd_oob1_q, rd_bank1_q;
  logic [AW-1:0]            rd_addr_q;
  logic                     rd_v2_q, rd_oob2_q, rd_bank2_q;
  logic [1:0][PIX_BITS-1:0] bank_rdata;
  logic [PIX_BITS-1:0]      pal_sel;
  rgb12_t                   pal_q [PAL_N];
  rgb12_t                   rgb_q;
  logic                     rgb_valid_q;

  assign busy = (state_q == CLEAR);

  // ---------------------------------------------------------------- address
  assign wr_ok = wr_en_i && !busy &&
                 ({1'b0, wr_x_i} < X_LIM) && ({1'b0, wr_y_i} < Y_LIM);
  assign wr_addr_d = AW'(wr_y_i) * ROW_STRIDE + AW'(wr_x_i);

  // Out-of-range reads still flow through the pipe but are forced to
  // palette entry 0; address 0 keeps the BRAM read in bounds.
  assign rd_oob_d  = ({1'b0, rd_x_i} >= X_LIM) || ({1'b0, rd_y_i} >= Y_LIM);
  assign rd_addr_d = rd_oob_d ? '0 : (AW'(rd_y_i) * ROW_STRIDE + AW'(rd_x_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_idx_q   <= '0;
      wr_bank_q  <= 1'b0;
      rd_v1_q    <= 1'b0;
      rd_oob1_q  <= 1'b0;
      rd_bank1_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      wr_en_q    <= wr_ok;
      wr_addr_q  <= wr_addr_d;
      wr_idx_q   <= wr_idx_i;
      wr_bank_q  <= ~front_sel_q;
      rd_v1_q    <= rd_valid_i;
      rd_oob1_q  <= rd_oob_d;
      rd_bank1_q <= front_sel_q;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // ------------------------------------------------------------------ banks
  // Each bank arbitrates its own write port. A clear owns the back bank; a
  // user write that was accepted just before the clear began and lands on
  // the same bank loses, which is harmless because the clear sweeps every
  // address after it anyway.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic                clr_we;
      logic                usr_we;
      logic                we;
      logic [AW-1:0]       waddr;
      logic [PIX_BITS-1:0] wdata;

      assign clr_we = busy && (front_sel_q != 1'(gi));
      assign usr_we = wr_en_q && (wr_bank_q == 1'(gi));
      assign we     = clr_we || usr_we;
      assign waddr  = clr_we ? clr_cnt_q : wr_addr_q;
      assign wdata  = clr_we ? PIX_BITS'(CLEAR_IDX) : wr_idx_q;

      if (gi == 0) begin : g_preload
        fb_bank #(
          .DEPTH    (N),
          .DW       (PIX_BITS),
          .AW       (AW),
          .INIT_FILE(INIT_FILE)
        ) u_bank (
          .clk    (clk),
          .we_i   (we),
          .waddr_i(waddr),
          .wdata_i(wdata),
          .raddr_i(rd_addr_q),
          .rdata_o(bank_rdata[gi])
        );
      end else begin : g_plain
        fb_bank #(
          .DEPTH    (N),
          .DW       (PIX_BITS),
          .AW       (AW),
          .INIT_FILE("")
        ) u_bank (
          .clk    (clk),
          .we_i   (we),
          .waddr_i(waddr),
          .wdata_i(wdata),
          .raddr_i(rd_addr_q),
          .rdata_o(bank_rdata[gi])
        );
      end
    end
  endgenerate

  // Sidebands travelling alongside the BRAM read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v2_q    <= 1'b0;
      rd_oob2_q  <= 1'b0;
      rd_bank2_q <= 1'b0;
    end else begin
      rd_v2_q    <= rd_v1_q;
      rd_oob2_q  <= rd_oob1_q;
      rd_bank2_q <= rd_bank1_q;
    end
  end

  // ---------------------------------------------------------------- palette
  assign pal_sel = rd_oob2_q ? '0 : bank_rdata[rd_bank2_q];

  // The palette stage reads pal_q before a same-edge palette write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= default_palette(i);
      end
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
    end else begin
      if (pal_we_i) begin
        pal_q[pal_addr_i] <= pal_rgb_i;
      end
      rgb_valid_q <= rd_v2_q;
      if (rd_v2_q) begin
        rgb_q <= pal_q[pal_sel];
      end
    end
  end

  // ---------------------------------------------------- clear FSM and swap
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        // Further clear requests are ignored until the sweep finishes.
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request arriving with vsync counts immediately; any vsync seen while
  // clearing leaves the request pending for a later frame.
  always_comb begin
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q | swap_req_i;
    if (vsync_i && !busy && (swap_pending_q || swap_req_i)) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      clr_cnt_q      <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign wr_ready_o     = !busy;
  assign busy_o         = busy;
  assign swap_pending_o = swap_pending_q;
  assign front_sel_o    = front_sel_q;
  assign rgb_out_o      = rgb_q;
  assign rgb_valid_o    = rgb_valid_q;

endmodule
